seq_divider32: RTL and testbench



---
 rtl/seq_divider32.sv | 152 +++++++++++++++
 tb/tb_seq_divider32.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle unsigned restoring divider, one quotient
// bit per clock, start/done handshake.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_i         request, taken only while busy_o = 0
//   dividend_i      numerator, latched with accepted start
//   divisor_i       denominator, latched with accepted start
//   busy_o          division in progress
//   done_o          one-cycle pulse, results valid
//   quotient_o      registered quotient
//   remainder_o     registered remainder
//   div_by_zero_o   registered, set when latched divisor was 0
//
// Build option: DIVZERO_BYPASS_EN makes a zero-divisor request skip
// the iteration and complete in one cycle with the same results.

module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dq_nx;
  logic             load;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // Its MSB is the borrow.
  assign trial = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit  = ~trial[WIDTH];

  // On borrow the dropped top bit of rem_q is always 0, because the
  // shifted remainder was smaller than a WIDTH-bit divisor.
  assign rem_nx = qbit ? trial[WIDTH-1:0]
                       : {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};

  // Dividend bits leave at the top while quotient bits enter at the
  // bottom, so after WIDTH steps the register holds the quotient.
  assign dq_nx = {dq_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    load    = 1'b0;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        load = start_i;
      end
      (state_q == S_RUN): begin
        dq_d  = dq_nx;
        rem_d = rem_nx;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          quo_d   = dq_nx;
          rmd_d   = rem_nx;
          dbz_d   = (dvs_q == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        load    = start_i;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      dq_d    = dividend_i;
      dvs_d   = divisor_i;
      rem_d   = '0;
      cnt_d   = CNT_LOAD;
      state_d = S_RUN;
`ifdef DIVZERO_BYPASS_EN
      if (divisor_i == '0) begin
        state_d = S_DONE;
        quo_d   = '1;
        rmd_d   = dividend_i;
        dbz_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: directed vectors for seq_divider32 with
// hand-computed quotient, remainder, flag and latency.

module tb_seq_divider32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dbz;

  int nvec = 0;
  int nerr = 0;
  int lat;
  int nbusy;
  int ndone;

`ifdef DIVZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  seq_divider32 #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .dividend_i    (dvd),
    .divisor_i     (dvs),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quo),
    .remainder_o   (rem),
    .div_by_zero_o (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; that edge is cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since the accepting edge.
  task automatic wait_done(output int l, output int nb);
    l  = 1;
    nb = 0;
    while (!done && l < 100) begin
      if (busy) nb++;
      tick();
      l++;
    end
  endtask

  // Idle for n cycles and count done pulses seen.
  task automatic idle(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) nd++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quo", quo, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", 32'(dbz), 0);
    tick();
    rst_n = 1'b1;
    tick();

    issue(32'd100, 32'd7);
    wait_done(lat, nbusy);
    chk("t1_lat", 32'(lat), 33);
    chk("t1_busy", 32'(nbusy), 32);
    chk("t1_quo", quo, 32'd14);
    chk("t1_rem", rem, 32'd2);
    chk("t1_dbz", 32'(dbz), 0);
    chk("t1_done_busy", 32'(busy), 0);

    idle(50, ndone);
    chk("hold_done", 32'(ndone), 0);
    chk("hold_quo", quo, 32'd14);
    chk("hold_rem", rem, 32'd2);

    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(lat, nbusy);
    chk("t2_lat", 32'(lat), 33);
    chk("t2_quo", quo, 32'hFFFF_FFFF);
    chk("t2_rem", rem, 32'd0);
    issue(32'd3, 32'd10);
    chk("b2b_busy", 32'(busy), 1);
    wait_done(lat, nbusy);
    chk("b2b_lat", 32'(lat), 33);
    chk("b2b_quo", quo, 32'd0);
    chk("b2b_rem", rem, 32'd3);
    tick();

    issue(32'd5, 32'd0);
    wait_done(lat, nbusy);
    chk("dz_lat", 32'(lat), ZLAT);
    chk("dz_quo", quo, 32'hFFFF_FFFF);
    chk("dz_rem", rem, 32'd5);
    chk("dz_flag", 32'(dbz), 1);
    tick();

    issue(32'd1000, 32'd3);
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        dvd   = 32'd9;
        dvs   = 32'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("ign_lat", 32'(lat), 33);
    chk("ign_quo", quo, 32'd333);
    chk("ign_rem", rem, 32'd1);
    chk("ign_dbz", 32'(dbz), 0);
    idle(40, ndone);
    chk("ign_nodone", 32'(ndone), 0);
    chk("ign_hold", quo, 32'd333);

    issue(32'hDEAD_BEEF, 32'h10);
    for (int i = 2; i < 15; i++) tick();
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_quo", quo, 0);
    chk("mr_rem", rem, 0);
    chk("mr_dbz", 32'(dbz), 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(40, ndone);
    chk("mr_nodone", 32'(ndone), 0);
    chk("mr_idle", 32'(busy), 0);
    issue(32'hDEAD_BEEF, 32'h10);
    wait_done(lat, nbusy);
    chk("fr_lat", 32'(lat), 33);
    chk("fr_quo", quo, 32'h0DEA_DBEE);
    chk("fr_rem", rem, 32'hF);
    tick();
    chk("fr_pulse", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
